// File: rtl/dual_port_ram.sv
// dual_port_ram
// True dual-port RAM with one clock. Each port can read or write any word
// on every rising edge. Read data is registered, and writes pass through to
// the same port's output. Read-during-write returns the old stored word to
// the reading port. When both ports write the same word, port A wins.
// Every word is held in resettable flops so that an asynchronous reset
// clears the entire array at once.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset (clears outputs and all words)
//   we_a/b     per-port write enable
//   addr_a/b   per-port word address
//   din_a/b    per-port write data
//   dout_a/b   per-port registered read / write-through data
//   collision  registered flag: last edge had addr_a==addr_b with a write
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d;
  logic [DATA_WIDTH-1:0] dout_b_q, dout_b_d;
  logic                  collision_q, collision_d;

  // Next-state logic. Reads see mem_q, which holds the pre-edge contents,
  // so read-before-write happens naturally. Port A's write is applied
  // after port B's write so that A overwrites B on a shared address.
  always_comb begin
    mem_d = mem_q;
    if (we_b) mem_d[addr_b] = din_b;
    if (we_a) mem_d[addr_a] = din_a;

    dout_a_d    = we_a ? din_a : mem_q[addr_a];
    dout_b_d    = we_b ? din_b : mem_q[addr_b];
    collision_d = (addr_a == addr_b) && (we_a || we_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dout_a_q    <= '0;
      dout_b_q    <= '0;
      collision_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      dout_a_q    <= dout_a_d;
      dout_b_q    <= dout_b_d;
      collision_q <= collision_d;
    end
  end

  assign dout_a    = dout_a_q;
  assign dout_b    = dout_b_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Testbench for dual_port_ram. A behavioural memory model predicts each
// edge's outputs when stimulus is driven. The predictions are queued and
// then compared after the edge.
module tb_dual_port_ram;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          we_a = 1'b0;
  logic          we_b = 1'b0;
  logic [AW-1:0] addr_a = '0;
  logic [AW-1:0] addr_b = '0;
  logic [DW-1:0] din_a = '0;
  logic [DW-1:0] din_b = '0;
  logic [DW-1:0] dout_a;
  logic [DW-1:0] dout_b;
  logic          collision;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          col;
  } exp_t;

  exp_t          exp_q [$];
  exp_t          last_exp;
  logic [DW-1:0] model_mem [DEPTH];
  int            error_count = 0;
  int            check_count = 0;

  dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_a      (we_a),
    .addr_a    (addr_a),
    .din_a     (din_a),
    .dout_a    (dout_a),
    .we_b      (we_b),
    .addr_b    (addr_b),
    .din_b     (din_b),
    .dout_b    (dout_b),
    .collision (collision)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Watchdog so that the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Clear the model to mirror the effect of reset.
  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // Drive one edge of stimulus at the falling edge and predict the outputs
  // from the model. After the rising edge, pop the prediction and compare.
  task automatic applyStimulus(input logic wa, input logic [AW-1:0] aa,
                               input logic [DW-1:0] da, input logic wb,
                               input logic [AW-1:0] ab, input logic [DW-1:0] db);
    exp_t e;
    exp_t got;
    @(negedge clk);
    we_a = wa; addr_a = aa; din_a = da;
    we_b = wb; addr_b = ab; din_b = db;
    e.a   = wa ? da : model_mem[aa];
    e.b   = wb ? db : model_mem[ab];
    e.col = (aa == ab) && (wa || wb);
    if (wb) model_mem[ab] = db;
    if (wa) model_mem[aa] = da;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    checkOutput("dout_a", 32'(dout_a), 32'(got.a));
    checkOutput("dout_b", 32'(dout_b), 32'(got.b));
    checkOutput("collision", 32'(collision), 32'(got.col));
    last_exp = got;
  endtask

  // Move the addresses between edges. The outputs must not follow them.
  task automatic holdCheck();
    #1;
    addr_a = addr_a + 4'd7;
    addr_b = addr_b + 4'd9;
    #1;
    checkOutput("hold_dout_a", 32'(dout_a), 32'(last_exp.a));
    checkOutput("hold_dout_b", 32'(dout_b), 32'(last_exp.b));
  endtask

  initial begin
    clearModel();

    // Power-on reset: assert it asynchronously, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_dout_a", 32'(dout_a), 32'h0);
    checkOutput("rst_dout_b", 32'(dout_b), 32'h0);
    checkOutput("rst_collision", 32'(collision), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Port A write-through sequence.
    applyStimulus(1'b1, 4'd1, 8'hA5, 1'b0, 4'd0, 8'h00);
    applyStimulus(1'b1, 4'd2, 8'h5A, 1'b0, 4'd0, 8'h00);
    // Port B write, then read back another word.
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 8'h3C);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd2, 8'h00);
    // Registered reads on both ports.
    applyStimulus(1'b0, 4'd1, 8'h00, 1'b0, 4'd3, 8'h00);
    holdCheck();
    applyStimulus(1'b0, 4'd2, 8'h00, 1'b0, 4'd3, 8'h00);
    // Write/write collision: port A wins.
    applyStimulus(1'b1, 4'd5, 8'h11, 1'b1, 4'd5, 8'h22);
    applyStimulus(1'b0, 4'd5, 8'h00, 1'b0, 4'd6, 8'h00);
    checkOutput("ww_winner_a", 32'(dout_a), 32'h11);
    applyStimulus(1'b0, 4'd6, 8'h00, 1'b0, 4'd5, 8'h00);
    checkOutput("ww_winner_b", 32'(dout_b), 32'h11);
    // Read/write collision: reader sees the old word, then the new one.
    applyStimulus(1'b1, 4'd4, 8'h77, 1'b0, 4'd4, 8'h00);
    checkOutput("rw_old_b", 32'(dout_b), 32'h00);
    checkOutput("rw_collision", 32'(collision), 32'h1);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd4, 8'h00);
    checkOutput("rw_new_b", 32'(dout_b), 32'h77);
    // Same address on both ports, no write: no collision.
    applyStimulus(1'b0, 4'd4, 8'h00, 1'b0, 4'd4, 8'h00);
    // Writes to different addresses in one cycle, then read both back.
    applyStimulus(1'b1, 4'd14, 8'hC3, 1'b1, 4'd15, 8'h96);
    applyStimulus(1'b0, 4'd15, 8'h00, 1'b0, 4'd14, 8'h00);
    holdCheck();

    // Random traffic over a narrow address range to provoke collisions.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end

    // Mid-sequence reset between edges, after writes with nonzero outputs.
    applyStimulus(1'b1, 4'd1, 8'hE7, 1'b1, 4'd1, 8'h3B);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_dout_a", 32'(dout_a), 32'h0);
    checkOutput("mid_rst_dout_b", 32'(dout_b), 32'h0);
    checkOutput("mid_rst_collision", 32'(collision), 32'h0);
    clearModel();
    // Writes while reset is held must be ignored.
    @(negedge clk);
    we_a = 1'b1; addr_a = 4'd1; din_a = 8'hFF;
    we_b = 1'b1; addr_b = 4'd1; din_b = 8'hEE;
    @(posedge clk);
    #1;
    checkOutput("rst_write_dout_a", 32'(dout_a), 32'h0);
    checkOutput("rst_write_collision", 32'(collision), 32'h0);
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0;
    rst_n = 1'b1;
    // Every word must read back as zero after release.
    applyStimulus(1'b0, 4'd1, 8'h00, 1'b0, 4'd5, 8'h00);
    checkOutput("post_rst_addr1", 32'(dout_a), 32'h00);
    applyStimulus(1'b0, 4'd2, 8'h00, 1'b0, 4'd3, 8'h00);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
